eth_ind_csr_bridge: RTL and testbench

Multi-channel successor of the single-port Ethernet CSR block: decodes CCI-P MMIO reads/writes into an 8-entry 64-bit CSR window and drives a shared indirect register bus towards NUM_CH Ethernet MAC/PHY channels. A proper valid/ready plus response handshake replaces the fixed pulse-extender command, with a busy/done/timeout status word and sticky error flags. Sits between the CCI-P interface register stage and the per-channel Ethernet CSR fabric, entirely in the pClk domain; any clock crossing sits downstream of this block.

---
 rtl/eth_ind_csr_pkg.sv | 35 +++
 rtl/eth_ind_req_engine.sv | 116 +++++++++++
 rtl/eth_ind_csr_bridge.sv | 161 ++++++++++++++++
 tb/tb_eth_ind_csr_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_ind_csr_pkg.sv
// Shared constants, CSR map and engine state type for the indirect Ethernet CSR bridge.
package eth_ind_csr_pkg;

  localparam logic [2:0] CSR_DFH     = 3'd0;
  localparam logic [2:0] CSR_ID_L    = 3'd1;
  localparam logic [2:0] CSR_ID_H    = 3'd2;
  localparam logic [2:0] CSR_INIT    = 3'd3;
  localparam logic [2:0] CSR_CMD     = 3'd4;
  localparam logic [2:0] CSR_WDATA   = 3'd5;
  localparam logic [2:0] CSR_STATUS  = 3'd6;
  localparam logic [2:0] CSR_SCRATCH = 3'd7;

  localparam int ST_BUSY     = 32;
  localparam int ST_DONE     = 33;
  localparam int ST_TMO      = 34;
  localparam int ST_ERR_BUSY = 35;
  localparam int ST_ERR_CMD  = 36;

  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_CH_LSB   = 16;
  localparam int CMD_WR       = 24;
  localparam int CMD_RD       = 25;
  localparam logic [63:0] CMD_MASK = 64'h0000_0000_0307_FFFF;

  localparam logic [63:0] DFH      = 64'h1000_0000_0000_0001;
  localparam logic [63:0] UNMAPPED = 64'h0000_DEAD_C0DE_0000;
  localparam logic [31:0] TMO_DATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } eng_state_e;

endpackage

// File: rtl/eth_ind_req_engine.sv
// Indirect request engine: request/response FSM, timeout counter, request latches and read-data capture.
module eth_ind_req_engine
  import eth_ind_csr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [2:0]        i_ch,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [2:0]        o_req_ch,
  output logic              o_req_wr,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [DATA_W-1:0] o_req_wdata,
  input  logic              i_rsp_valid,
  input  logic [DATA_W-1:0] i_rsp_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [DATA_W-1:0] o_rd_data
);

  // The last permitted cycle is the one where the counter holds LIMIT-1.
  localparam logic [TMO_W-1:0] LIMIT_M1 = {TMO_W{1'b1}} - TMO_W'(1);

  eng_state_e        r_state, w_next;
  logic [TMO_W-1:0]  r_cnt;
  logic [2:0]        r_ch;
  logic              r_wr, r_done, r_tmo;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rd_data;
  logic              w_expire, w_complete, w_tmo;

  assign w_expire = (r_cnt >= LIMIT_M1);

  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_REQ;
      S_REQ: begin
        if (i_req_ready) begin
          w_next = S_RSP;
        end else if (w_expire) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      // A response in the expiry cycle still counts as a completion.
      S_RSP: begin
        if (i_rsp_valid) begin
          w_next     = S_IDLE;
          w_complete = 1'b1;
        end else if (w_expire) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_cnt <= '0;
      else                   r_cnt <= r_cnt + TMO_W'(1);
      if ((r_state == S_IDLE) && i_start) begin
        r_ch    <= i_ch;
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_done  <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (w_complete) begin
        r_done <= 1'b1;
        if (!r_wr) r_rd_data <= i_rsp_rdata;
      end
      if (w_tmo) begin
        r_done    <= 1'b1;
        r_tmo     <= 1'b1;
        r_rd_data <= TMO_DATA[DATA_W-1:0];
      end
    end
  end

  assign o_req_valid = (r_state == S_REQ);
  assign o_req_ch    = r_ch;
  assign o_req_wr    = r_wr;
  assign o_req_addr  = r_addr;
  assign o_req_wdata = r_wdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_timeout   = r_tmo;
  assign o_rd_data   = r_rd_data;

endmodule

// File: rtl/eth_ind_csr_bridge.sv
// MMIO CSR window decoding into a shared indirect register bus for NUM_CH Ethernet channels.
module eth_ind_csr_bridge
  import eth_ind_csr_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 32,
  parameter int          TMO_W    = 10,
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic              pClk,
  input  logic              pck_cp2af_softReset,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [63:0]       mmio_wdata,
  output logic              mmio_rsp_valid,
  output logic [8:0]        mmio_rsp_tid,
  output logic [63:0]       mmio_rsp_data,
  output logic              eth_req_valid,
  input  logic              eth_req_ready,
  output logic [2:0]        eth_req_ch,
  output logic              eth_req_wr,
  output logic [ADDR_W-1:0] eth_req_addr,
  output logic [DATA_W-1:0] eth_req_wdata,
  input  logic              eth_rsp_valid,
  input  logic [DATA_W-1:0] eth_rsp_rdata,
  output logic [NUM_CH-1:0] init_start,
  input  logic [NUM_CH-1:0] init_done
);

  logic              w_hit, w_busy, w_done, w_tmo;
  logic [2:0]        w_idx, w_cmd_ch;
  logic              w_cmd_wr, w_cmd_wrb, w_cmd_rdb, w_cmd_bad, w_st_wr, w_start;
  logic [DATA_W-1:0] w_eng_rd;
  logic [63:0]       w_rd_data;
  logic              w_unused_ok;

  logic [63:0]       r_scratch, r_cmd;
  logic [DATA_W-1:0] r_wdata;
  logic [NUM_CH-1:0] r_init_start, r_init_done;
  logic              r_err_busy, r_err_cmd;
  logic              r_p1_vld, r_rsp_vld;
  logic [8:0]        r_p1_tid, r_rsp_tid;
  logic [63:0]       r_p1_data, r_rsp_data;

  // Anything above the 8-entry window is unmapped.
  assign w_hit       = (mmio_addr[15:4] == 12'h0);
  assign w_idx       = mmio_addr[3:1];
  assign w_unused_ok = &{1'b0, mmio_addr[0]};

  assign w_cmd_wr  = mmio_wr_valid && w_hit && (w_idx == CSR_CMD);
  assign w_st_wr   = mmio_wr_valid && w_hit && (w_idx == CSR_STATUS);
  assign w_cmd_ch  = mmio_wdata[CMD_CH_LSB +: 3];
  assign w_cmd_wrb = mmio_wdata[CMD_WR];
  assign w_cmd_rdb = mmio_wdata[CMD_RD];
  assign w_cmd_bad = (w_cmd_wrb == w_cmd_rdb) || (32'(w_cmd_ch) >= 32'(NUM_CH));
  assign w_start   = w_cmd_wr && !w_busy && !w_cmd_bad;

  eth_ind_req_engine #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TMO_W (TMO_W)
  ) u_engine (
    .clk        (pClk),
    .rst        (pck_cp2af_softReset),
    .i_start    (w_start),
    .i_ch       (w_cmd_ch),
    .i_addr     (mmio_wdata[CMD_ADDR_LSB +: ADDR_W]),
    .i_wr       (w_cmd_wrb),
    .i_wdata    (r_wdata),
    .o_req_valid(eth_req_valid),
    .i_req_ready(eth_req_ready),
    .o_req_ch   (eth_req_ch),
    .o_req_wr   (eth_req_wr),
    .o_req_addr (eth_req_addr),
    .o_req_wdata(eth_req_wdata),
    .i_rsp_valid(eth_rsp_valid),
    .i_rsp_rdata(eth_rsp_rdata),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_timeout  (w_tmo),
    .o_rd_data  (w_eng_rd)
  );

  always_comb begin
    w_rd_data = UNMAPPED;
    if (w_hit) begin
      case (w_idx)
        CSR_DFH:     w_rd_data = DFH;
        CSR_ID_L:    w_rd_data = AFU_ID_L;
        CSR_ID_H:    w_rd_data = AFU_ID_H;
        CSR_INIT:    w_rd_data = {48'h0, 8'(r_init_done), 8'(r_init_start)};
        CSR_CMD:     w_rd_data = r_cmd;
        CSR_WDATA:   w_rd_data = 64'(r_wdata);
        CSR_STATUS:  w_rd_data = {27'h0, r_err_cmd, r_err_busy, w_tmo, w_done, w_busy, 32'(w_eng_rd)};
        CSR_SCRATCH: w_rd_data = r_scratch;
        default:     w_rd_data = UNMAPPED;
      endcase
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_scratch    <= '0;
      r_cmd        <= '0;
      r_wdata      <= '0;
      r_init_start <= '0;
      r_init_done  <= '0;
      r_err_busy   <= 1'b0;
      r_err_cmd    <= 1'b0;
    end else begin
      r_init_done <= init_done;
      if (mmio_wr_valid && w_hit) begin
        case (w_idx)
          CSR_INIT:    r_init_start <= mmio_wdata[NUM_CH-1:0];
          CSR_WDATA:   r_wdata      <= mmio_wdata[DATA_W-1:0];
          CSR_SCRATCH: r_scratch    <= mmio_wdata;
          default: ;
        endcase
      end
      if (w_cmd_wr && !w_busy) r_cmd <= mmio_wdata & CMD_MASK;
      // Setting an error flag takes priority over a same-cycle W1C.
      if (w_cmd_wr && w_busy)                   r_err_busy <= 1'b1;
      else if (w_st_wr && mmio_wdata[ST_ERR_BUSY]) r_err_busy <= 1'b0;
      if (w_cmd_wr && !w_busy && w_cmd_bad)     r_err_cmd <= 1'b1;
      else if (w_st_wr && mmio_wdata[ST_ERR_CMD]) r_err_cmd <= 1'b0;
    end
  end

  // Read data is sampled on the request cycle, so a STATUS read sees pre-update state.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_p1_vld   <= 1'b0;
      r_p1_tid   <= '0;
      r_p1_data  <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_tid  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_p1_vld  <= mmio_rd_valid;
      r_rsp_vld <= r_p1_vld;
      if (mmio_rd_valid) begin
        r_p1_tid  <= mmio_tid;
        r_p1_data <= w_rd_data;
      end
      if (r_p1_vld) begin
        r_rsp_tid  <= r_p1_tid;
        r_rsp_data <= r_p1_data;
      end
    end
  end

  assign mmio_rsp_valid = r_rsp_vld;
  assign mmio_rsp_tid   = r_rsp_tid;
  assign mmio_rsp_data  = r_rsp_data;
  assign init_start     = r_init_start;

endmodule

// File: tb/tb_eth_ind_csr_bridge.sv
// Bench for eth_ind_csr_bridge: CSR vector table, directed transaction sequences, randomized model check.
module tb_eth_ind_csr_bridge;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO_W  = 6;
  localparam int LIMIT  = (1 << TMO_W) - 1;
  localparam logic [63:0] ID_L  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH_V = 64'h1000_0000_0000_0001;
  localparam logic [63:0] UNM_V = 64'h0000_DEAD_C0DE_0000;

  logic              pClk, pck_cp2af_softReset;
  logic              mmio_wr_valid, mmio_rd_valid;
  logic [15:0]       mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wdata;
  logic              mmio_rsp_valid;
  logic [8:0]        mmio_rsp_tid;
  logic [63:0]       mmio_rsp_data;
  logic              eth_req_valid, eth_req_ready, eth_req_wr;
  logic [2:0]        eth_req_ch;
  logic [ADDR_W-1:0] eth_req_addr;
  logic [DATA_W-1:0] eth_req_wdata;
  logic              eth_rsp_valid;
  logic [DATA_W-1:0] eth_rsp_rdata;
  logic [NUM_CH-1:0] init_start, init_done;

  eth_ind_csr_bridge #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W),
    .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)
  ) dut (
    .pClk(pClk), .pck_cp2af_softReset(pck_cp2af_softReset),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid), .mmio_rsp_data(mmio_rsp_data),
    .eth_req_valid(eth_req_valid), .eth_req_ready(eth_req_ready), .eth_req_ch(eth_req_ch),
    .eth_req_wr(eth_req_wr), .eth_req_addr(eth_req_addr), .eth_req_wdata(eth_req_wdata),
    .eth_rsp_valid(eth_rsp_valid), .eth_rsp_rdata(eth_rsp_rdata),
    .init_start(init_start), .init_done(init_done)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int errors = 0;
  int checks = 0;
  logic [8:0] tid_ctr = 9'd1;

  typedef struct {
    string             name;
    bit                do_wr;
    logic [15:0]       wa;
    logic [63:0]       wd;
    logic [NUM_CH-1:0] idone;
    logic [15:0]       ra;
    logic [63:0]       exp;
  } vec_t;
  vec_t tbl[13];

  task automatic step();
    @(posedge pClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mmio_wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1; mmio_addr = a; mmio_wdata = d;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_rd(input logic [15:0] a, output logic [63:0] d);
    logic [8:0] t;
    t = tid_ctr; tid_ctr++;
    mmio_rd_valid = 1'b1; mmio_addr = a; mmio_tid = t;
    step();
    mmio_rd_valid = 1'b0;
    chk("rsp_early", 64'(mmio_rsp_valid), 64'd0);
    step();
    chk("rsp_valid", 64'(mmio_rsp_valid), 64'd1);
    chk("rsp_tid", 64'(mmio_rsp_tid), 64'(t));
    d = mmio_rsp_data;
  endtask

  function automatic logic [63:0] mk_cmd(input int ch, input bit wr, input bit rd, input logic [15:0] a);
    return {38'h0, rd, wr, 5'h0, 3'(ch), a};
  endfunction

  function automatic logic [63:0] st_word(input logic [31:0] rd, input bit busy, input bit done,
                                          input bit tmo, input bit eb, input bit ec);
    return {27'h0, ec, eb, tmo, done, busy, rd};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int n;
    pck_cp2af_softReset = 1'b1;
    mmio_wr_valid = 0; mmio_rd_valid = 0; mmio_addr = 0; mmio_tid = 0; mmio_wdata = 0;
    eth_req_ready = 0; eth_rsp_valid = 0; eth_rsp_rdata = 0; init_done = 0;
    step(); step();
    chk("rst_req_valid", 64'(eth_req_valid), 0);
    chk("rst_rsp_valid", 64'(mmio_rsp_valid), 0);
    chk("rst_outs", {eth_req_ch, eth_req_wr, eth_req_addr, eth_req_wdata, init_start}, 0);
    chk("rst_rsp_data", mmio_rsp_data, 0);
    pck_cp2af_softReset = 1'b0;
    step();

    // ---- CSR vector table ----
    tbl[0]  = '{"dfh",          0, 16'h0,  64'h0, 4'h0, 16'h0000, DFH_V};
    tbl[1]  = '{"scratch_rst",  0, 16'h0,  64'h0, 4'h0, 16'h000E, 64'h0};
    tbl[2]  = '{"status_rst",   0, 16'h0,  64'h0, 4'h0, 16'h000C, 64'h0};
    tbl[3]  = '{"unmapped",     0, 16'h0,  64'h0, 4'h0, 16'h0010, UNM_V};
    tbl[4]  = '{"id_l",         0, 16'h0,  64'h0, 4'h0, 16'h0002, ID_L};
    tbl[5]  = '{"id_h",         0, 16'h0,  64'h0, 4'h0, 16'h0004, ID_H};
    tbl[6]  = '{"cmd_rst",      0, 16'h0,  64'h0, 4'h0, 16'h0008, 64'h0};
    tbl[7]  = '{"scratch_rw",   1, 16'h000E, 64'hA5A5_5A5A_0123_4567, 4'h0, 16'h000E, 64'hA5A5_5A5A_0123_4567};
    tbl[8]  = '{"unmapped_wr",  1, 16'h001E, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 16'h000E, 64'hA5A5_5A5A_0123_4567};
    tbl[9]  = '{"wdata_trunc",  1, 16'h000A, 64'hFFFF_FFFF_1234_5678, 4'h0, 16'h000A, 64'h0000_0000_1234_5678};
    tbl[10] = '{"init_wr",      1, 16'h0006, 64'h0000_0000_0000_00FF, 4'h0, 16'h0006, 64'h0000_0000_0000_000F};
    tbl[11] = '{"init_done",    0, 16'h0,  64'h0, 4'hA, 16'h0006, 64'h0000_0000_0000_0A0F};
    tbl[12] = '{"init_both",    1, 16'h0006, 64'h0000_0000_0000_0005, 4'h5, 16'h0006, 64'h0000_0000_0000_0505};
    foreach (tbl[i]) begin
      init_done = tbl[i].idone;
      step();
      if (tbl[i].do_wr) mmio_wr(tbl[i].wa, tbl[i].wd);
      mmio_rd(tbl[i].ra, d);
      chk(tbl[i].name, d, tbl[i].exp);
    end
    chk("init_start_port", 64'(init_start), 64'h5);
    init_done = 0;

    // ---- write to ch2 with delayed ready and response ----
    mmio_wr(16'h0008, mk_cmd(2, 1, 0, 16'h0040));
    for (int i = 0; i < 3; i++) begin
      chk("wr_req_hold", {eth_req_valid, eth_req_ch, eth_req_wr, eth_req_addr, eth_req_wdata},
          {1'b1, 3'd2, 1'b1, 16'h0040, 32'h1234_5678});
      step();
    end
    eth_req_ready = 1;
    chk("wr_req_at_ready", 64'(eth_req_valid), 1);
    step();
    eth_req_ready = 0;
    chk("wr_req_dropped", 64'(eth_req_valid), 0);
    mmio_rd(16'h000C, d);
    chk("wr_status_busy", d, st_word(0, 1, 0, 0, 0, 0));
    step(); step(); step();
    eth_rsp_valid = 1; step(); eth_rsp_valid = 0;
    mmio_rd(16'h000C, d);
    chk("wr_status_done", d, st_word(0, 0, 1, 0, 0, 0));

    // ---- read from ch1; STATUS read coincident with completion ----
    mmio_wr(16'h0008, mk_cmd(1, 0, 1, 16'h1234));
    chk("rd_req", {eth_req_valid, eth_req_ch, eth_req_wr, eth_req_addr}, {1'b1, 3'd1, 1'b0, 16'h1234});
    eth_req_ready = 1; step(); eth_req_ready = 0;
    step();
    eth_rsp_valid = 1; eth_rsp_rdata = 32'hCAFE_F00D;
    mmio_rd_valid = 1; mmio_addr = 16'h000C; mmio_tid = tid_ctr;
    step();
    eth_rsp_valid = 0; mmio_rd_valid = 0;
    step();
    chk("coincident_tid", 64'(mmio_rsp_tid), 64'(tid_ctr));
    chk("coincident_status", mmio_rsp_data, st_word(0, 1, 0, 0, 0, 0));
    tid_ctr++;
    mmio_rd(16'h000C, d);
    chk("rd_status_done", d, st_word(32'hCAFE_F00D, 0, 1, 0, 0, 0));

    // ---- bad commands ----
    mmio_wr(16'h0008, mk_cmd(NUM_CH, 1, 0, 16'h0001));
    chk("badch_no_req0", 64'(eth_req_valid), 0);
    step();
    chk("badch_no_req1", 64'(eth_req_valid), 0);
    mmio_rd(16'h000C, d);
    chk("badch_err_cmd", d, st_word(32'hCAFE_F00D, 0, 1, 0, 0, 1));
    mmio_wr(16'h000C, 64'h1 << 36);
    mmio_rd(16'h000C, d);
    chk("err_cmd_w1c", d, st_word(32'hCAFE_F00D, 0, 1, 0, 0, 0));
    mmio_wr(16'h0008, mk_cmd(1, 1, 1, 16'h0002));
    chk("wrrd_no_req", 64'(eth_req_valid), 0);
    mmio_rd(16'h000C, d);
    chk("wrrd_err_cmd", d, st_word(32'hCAFE_F00D, 0, 1, 0, 0, 1));
    mmio_wr(16'h000C, 64'h3 << 35);

    // ---- CMD while busy, including on the completion cycle ----
    mmio_wr(16'h0008, mk_cmd(0, 0, 1, 16'h0010));
    mmio_wr(16'h0008, mk_cmd(3, 1, 0, 16'hBEEF));
    chk("busy_req_kept", {eth_req_valid, eth_req_ch, eth_req_wr, eth_req_addr}, {1'b1, 3'd0, 1'b0, 16'h0010});
    mmio_rd(16'h0008, d);
    chk("busy_cmd_unchanged", d, mk_cmd(0, 0, 1, 16'h0010));
    eth_req_ready = 1; step(); eth_req_ready = 0;
    mmio_wr(16'h000C, 64'h1 << 35);
    eth_rsp_valid = 1; eth_rsp_rdata = 32'h0BAD_F00D;
    mmio_wr(16'h0008, mk_cmd(2, 1, 0, 16'h0005));
    eth_rsp_valid = 0;
    chk("ret_idle_rejected", 64'(eth_req_valid), 0);
    mmio_rd(16'h000C, d);
    chk("busy_status", d, st_word(32'h0BAD_F00D, 0, 1, 0, 1, 0));
    mmio_wr(16'h000C, 64'h1 << 35);
    mmio_rd(16'h000C, d);
    chk("err_busy_w1c", d, st_word(32'h0BAD_F00D, 0, 1, 0, 0, 0));

    // ---- timeout in REQ ----
    mmio_wr(16'h0008, mk_cmd(3, 0, 1, 16'h0077));
    n = 0;
    while (eth_req_valid && n < LIMIT + 10) begin n++; step(); end
    chk("tmo_valid_cycles", 64'(n), 64'(LIMIT));
    mmio_rd(16'h000C, d);
    chk("tmo_status", d, st_word(32'hDEAD_DEAD, 0, 1, 1, 0, 0));

    // ---- response exactly on the expiry cycle wins ----
    mmio_wr(16'h0008, mk_cmd(0, 0, 1, 16'h0001));
    eth_req_ready = 1; step(); eth_req_ready = 0;
    repeat (LIMIT - 2) step();
    eth_rsp_valid = 1; eth_rsp_rdata = 32'h1357_9BDF; step(); eth_rsp_valid = 0;
    mmio_rd(16'h000C, d);
    chk("tmo_rsp_wins", d, st_word(32'h1357_9BDF, 0, 1, 0, 0, 0));
    // one cycle later the timeout has already fired
    mmio_wr(16'h0008, mk_cmd(0, 0, 1, 16'h0001));
    eth_req_ready = 1; step(); eth_req_ready = 0;
    repeat (LIMIT - 1) step();
    eth_rsp_valid = 1; eth_rsp_rdata = 32'h2468_ACE0; step(); eth_rsp_valid = 0;
    mmio_rd(16'h000C, d);
    chk("tmo_rsp_late", d, st_word(32'hDEAD_DEAD, 0, 1, 1, 0, 0));

    // ---- reset mid-transaction ----
    mmio_wr(16'h0008, mk_cmd(1, 1, 0, 16'h0009));
    chk("pre_rst_valid", 64'(eth_req_valid), 1);
    #2 pck_cp2af_softReset = 1;
    #1 chk("rst_req_async_drop", 64'(eth_req_valid), 0);
    step(); pck_cp2af_softReset = 0; step();
    mmio_wr(16'h0008, mk_cmd(2, 0, 1, 16'h0003));
    eth_req_ready = 1; step(); eth_req_ready = 0;
    #2 pck_cp2af_softReset = 1;
    #1 chk("rst_in_rsp_valid", 64'(eth_req_valid), 0);
    step(); pck_cp2af_softReset = 0; step();
    eth_rsp_valid = 1; eth_rsp_rdata = 32'h7777_7777; step(); eth_rsp_valid = 0;
    mmio_rd(16'h000C, d);
    chk("late_rsp_ignored", d, st_word(0, 0, 0, 0, 0, 0));

    // ---- randomized transactions against a status-word model ----
    begin
      logic [31:0] m_rd;
      bit m_done, m_tmo, m_eb, m_ec;
      m_rd = 0; m_done = 0; m_tmo = 0; m_eb = 0; m_ec = 0;
      for (int it = 0; it < 30; it++) begin
        int ch, m, d1, d2, b;
        bit wr, rd, ok;
        logic [15:0] a;
        logic [31:0] wd, rdat;
        if ($urandom_range(0, 3) == 0) begin
          eth_rsp_valid = 1; eth_rsp_rdata = $urandom; step(); eth_rsp_valid = 0;
        end
        wd = $urandom;
        mmio_wr(16'h000A, 64'(wd));
        ch = $urandom_range(0, NUM_CH);
        m  = $urandom_range(0, 7);
        wr = (m == 7) || (m == 1) || (m == 3) || (m == 5);
        rd = (m == 7) || (m == 2) || (m == 4) || (m == 6);
        a  = 16'($urandom_range(0, 65535));
        ok = (wr != rd) && (ch < NUM_CH);
        mmio_wr(16'h0008, mk_cmd(ch, wr, rd, a));
        if (!ok) begin
          m_ec = 1;
          chk("rnd_rej0", 64'(eth_req_valid), 0);
          step();
          chk("rnd_rej1", 64'(eth_req_valid), 0);
        end else begin
          m_done = 0; m_tmo = 0;
          chk("rnd_req", {eth_req_valid, eth_req_ch, eth_req_wr, eth_req_addr}, {1'b1, 3'(ch), wr, a});
          if (wr) chk("rnd_wdata", 64'(eth_req_wdata), 64'(wd));
          d1 = $urandom_range(0, 4);
          d2 = $urandom_range(0, 4);
          repeat (d1) step();
          eth_req_ready = 1; step(); eth_req_ready = 0;
          repeat (d2) step();
          rdat = $urandom;
          eth_rsp_valid = 1; eth_rsp_rdata = rdat; step(); eth_rsp_valid = 0;
          if (rd) m_rd = rdat;
          m_done = 1;
        end
        if ($urandom_range(0, 2) == 0) begin
          b = $urandom_range(0, 3);
          mmio_wr(16'h000C, 64'(b) << 35);
          if (b[0]) m_eb = 0;
          if (b[1]) m_ec = 0;
        end
        mmio_rd(16'h000C, d);
        chk("rnd_status", d, st_word(m_rd, 0, m_done, m_tmo, m_eb, m_ec));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
